// File: rtl/exec_sequencer_pkg.sv
// Shared constants and types for the execute sequencer: opcode/funct values, ALU op codes,
// FSM state encoding and the decoder output record.
package exec_sequencer_pkg;

  localparam int unsigned D_WIDTH  = 32;
  localparam int unsigned RA_WIDTH = 5;

  // Major opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_MUL = 6'd24;
  localparam logic [5:0] FN_DIV = 6'd26;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluMul = 3'b010,
    AluDiv = 3'b011,
    AluShl = 3'b100,
    AluShr = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StExec = 2'd2,
    StWb   = 2'd3
  } state_e;

  // Source of ALU operand 2
  typedef enum logic [1:0] {
    OpbR2  = 2'd0,
    OpbSh  = 2'd1,
    OpbImm = 2'd2
  } opb_sel_e;

  typedef struct packed {
    logic     legal;
    alu_op_e  op_code;
    logic     uses_r2;
    opb_sel_e imm_sel;
    logic     dest_is_rt;
  } dec_t;

  // ADDI immediate {rd,sh,fn} widened to the datapath
  function automatic logic [D_WIDTH-1:0] ext_imm(input logic [15:0] imm, input bit sext);
    if (sext) begin
      return {{(D_WIDTH - 16){imm[15]}}, imm};
    end
    return {{(D_WIDTH - 16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Issue, RegFile and ALU signals of the execute sequencer.
// Optional Trap signal present when EXEC_DIV0_TRAP_EN is defined.
interface exec_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  import exec_sequencer_pkg::*;

  logic                Issue_valid;
  logic                Issue_ready;
  logic [D_WIDTH-1:0]  IR;
  logic [RA_WIDTH-1:0] R1_Addr;
  logic                R1_en;
  logic [RA_WIDTH-1:0] R2_Addr;
  logic                R2_en;
  logic [D_WIDTH-1:0]  R1_Data;
  logic [D_WIDTH-1:0]  R2_Data;
  logic [2:0]          op_code;
  logic [D_WIDTH-1:0]  operand1;
  logic [D_WIDTH-1:0]  operand2;
  logic                enable;
  logic [D_WIDTH-1:0]  result;
  logic [RA_WIDTH-1:0] W_Addr;
  logic [D_WIDTH-1:0]  W_Data;
  logic                W_en;
  logic                Retire;
  logic                Illegal;
  logic [CNT_W-1:0]    Retire_cnt;
`ifdef EXEC_DIV0_TRAP_EN
  logic                Trap;
`endif

  // Sequencer side
  modport master (
    input  Issue_valid, IR, R1_Data, R2_Data, result,
    output Issue_ready, R1_Addr, R1_en, R2_Addr, R2_en, op_code, operand1, operand2, enable,
    output W_Addr, W_Data, W_en, Retire, Illegal, Retire_cnt
`ifdef EXEC_DIV0_TRAP_EN
    , output Trap
`endif
  );

  // Fetch / RegFile / ALU side
  modport slave (
    output Issue_valid, IR, R1_Data, R2_Data, result,
    input  Issue_ready, R1_Addr, R1_en, R2_Addr, R2_en, op_code, operand1, operand2, enable,
    input  W_Addr, W_Data, W_en, Retire, Illegal, Retire_cnt
`ifdef EXEC_DIV0_TRAP_EN
    , input Trap
`endif
  );

endinterface

// File: rtl/exec_op_map.sv
// Combinational instruction classifier: {op,fn} -> legality, ALU op and operand routing.
module exec_op_map
  import exec_sequencer_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] fn_i,
  output dec_t       dec_o
);

  // Decode table; anything not listed is illegal
  always_comb begin
    dec_o.legal      = 1'b0;
    dec_o.op_code    = AluAdd;
    dec_o.uses_r2    = 1'b0;
    dec_o.imm_sel    = OpbR2;
    dec_o.dest_is_rt = 1'b0;
    if (op_i == OP_RTYPE) begin
      case (fn_i)
        FN_SLL: begin
          dec_o.legal   = 1'b1;
          dec_o.op_code = AluShl;
          dec_o.imm_sel = OpbSh;
        end
        FN_SRL: begin
          dec_o.legal   = 1'b1;
          dec_o.op_code = AluShr;
          dec_o.imm_sel = OpbSh;
        end
        FN_MUL: begin
          dec_o.legal   = 1'b1;
          dec_o.op_code = AluMul;
          dec_o.uses_r2 = 1'b1;
        end
        FN_DIV: begin
          dec_o.legal   = 1'b1;
          dec_o.op_code = AluDiv;
          dec_o.uses_r2 = 1'b1;
        end
        FN_ADD: begin
          dec_o.legal   = 1'b1;
          dec_o.op_code = AluAdd;
          dec_o.uses_r2 = 1'b1;
        end
        FN_SUB: begin
          dec_o.legal   = 1'b1;
          dec_o.op_code = AluSub;
          dec_o.uses_r2 = 1'b1;
        end
        default: ;
      endcase
    end else if (op_i == OP_ADDI) begin
      dec_o.legal      = 1'b1;
      dec_o.op_code    = AluAdd;
      dec_o.imm_sel    = OpbImm;
      dec_o.dest_is_rt = 1'b1;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute controller: IDLE -> READ -> EXEC -> WB, one instruction per 3 cycles.
// Optional feature: define EXEC_DIV0_TRAP_EN to turn divide-by-zero into a Trap pulse
// instead of a normal writeback/retire.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter bit          IMM_SEXT = 1'b0
) (
  input logic             Clk,
  input logic             Rst,
  exec_sequencer_if.master bus
);

  state_e              state_q, state_d;
  logic [D_WIDTH-1:0]  ir_q, ir_d;
  logic [D_WIDTH-1:0]  res_q, res_d;
  logic                issue_ready_q, issue_ready_d;
  logic                r1_en_q, r1_en_d;
  logic [RA_WIDTH-1:0] r1_addr_q, r1_addr_d;
  logic                r2_en_q, r2_en_d;
  logic [RA_WIDTH-1:0] r2_addr_q, r2_addr_d;
  logic                alu_en_q, alu_en_d;
  logic [2:0]          op_code_q, op_code_d;
  logic                w_en_q, w_en_d;
  logic [RA_WIDTH-1:0] w_addr_q, w_addr_d;
  logic                retire_q, retire_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef EXEC_DIV0_TRAP_EN
  logic                trap_q, trap_d;
  logic                div0;
`endif

  logic                accept;
  logic [D_WIDTH-1:0]  dec_ir;
  dec_t                dec;
  logic [RA_WIDTH-1:0] rs, rt, rd, dst;
  logic [4:0]          sh;

  // Issue_ready is only high in IDLE and WB, so it doubles as the accept qualifier
  assign accept = issue_ready_q & bus.Issue_valid;

  // Decode the incoming word on an accept, otherwise the captured one
  assign dec_ir = accept ? bus.IR : ir_q;
  assign rs     = dec_ir[25:21];
  assign rt     = dec_ir[20:16];
  assign rd     = dec_ir[15:11];
  assign sh     = dec_ir[10:6];
  assign dst    = dec.dest_is_rt ? rt : rd;

  exec_op_map u_op_map (
    .op_i  (dec_ir[31:26]),
    .fn_i  (dec_ir[5:0]),
    .dec_o (dec)
  );

`ifdef EXEC_DIV0_TRAP_EN
  // Divide-by-zero seen while the divisor is on the read port
  assign div0 = (op_code_q == AluDiv) && (bus.R2_Data == '0);
`endif

  // Next-state and next-output computation for the sequencer FSM
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    res_d         = res_q;
    cnt_d         = cnt_q;
    issue_ready_d = 1'b0;
    r1_en_d       = 1'b0;
    r1_addr_d     = '0;
    r2_en_d       = 1'b0;
    r2_addr_d     = '0;
    alu_en_d      = 1'b0;
    op_code_d     = '0;
    w_en_d        = 1'b0;
    w_addr_d      = '0;
    retire_d      = 1'b0;
    illegal_d     = 1'b0;
`ifdef EXEC_DIV0_TRAP_EN
    trap_d        = 1'b0;
`endif
    unique case (state_q)
      StIdle, StWb: begin
        state_d       = StIdle;
        issue_ready_d = 1'b1;
        if (accept) begin
          ir_d = bus.IR;
          if (dec.legal) begin
            state_d       = StRead;
            issue_ready_d = 1'b0;
            r1_en_d       = 1'b1;
            r1_addr_d     = (dec.imm_sel == OpbSh) ? rt : rs;
            r2_en_d       = dec.uses_r2;
            r2_addr_d     = dec.uses_r2 ? rt : '0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StRead: begin
        state_d   = StExec;
        alu_en_d  = 1'b1;
        op_code_d = dec.op_code;
      end
      StExec: begin
        state_d       = StWb;
        res_d         = bus.result;
        issue_ready_d = 1'b1;
        w_addr_d      = dst;
`ifdef EXEC_DIV0_TRAP_EN
        w_en_d   = (dst != '0) && !div0;
        retire_d = !div0;
        trap_d   = div0;
`else
        w_en_d   = (dst != '0);
        retire_d = 1'b1;
`endif
        if (retire_d) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d       = StIdle;
        issue_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset aborts any in-flight instruction
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= StIdle;
      ir_q          <= '0;
      res_q         <= '0;
      cnt_q         <= '0;
      issue_ready_q <= 1'b1;
      r1_en_q       <= 1'b0;
      r1_addr_q     <= '0;
      r2_en_q       <= 1'b0;
      r2_addr_q     <= '0;
      alu_en_q      <= 1'b0;
      op_code_q     <= '0;
      w_en_q        <= 1'b0;
      w_addr_q      <= '0;
      retire_q      <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef EXEC_DIV0_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      res_q         <= res_d;
      cnt_q         <= cnt_d;
      issue_ready_q <= issue_ready_d;
      r1_en_q       <= r1_en_d;
      r1_addr_q     <= r1_addr_d;
      r2_en_q       <= r2_en_d;
      r2_addr_q     <= r2_addr_d;
      alu_en_q      <= alu_en_d;
      op_code_q     <= op_code_d;
      w_en_q        <= w_en_d;
      w_addr_q      <= w_addr_d;
      retire_q      <= retire_d;
      illegal_q     <= illegal_d;
`ifdef EXEC_DIV0_TRAP_EN
      trap_q        <= trap_d;
`endif
    end
  end

  // ALU operands follow the read data combinationally, gated to EXEC
  always_comb begin
    bus.operand1 = '0;
    bus.operand2 = '0;
    if (state_q == StExec) begin
      bus.operand1 = bus.R1_Data;
      unique case (dec.imm_sel)
        OpbSh:   bus.operand2 = D_WIDTH'(sh);
        OpbImm:  bus.operand2 = ext_imm(dec_ir[15:0], IMM_SEXT);
        default: bus.operand2 = bus.R2_Data;
      endcase
    end
  end

  assign bus.Issue_ready = issue_ready_q;
  assign bus.R1_en       = r1_en_q;
  assign bus.R1_Addr     = r1_addr_q;
  assign bus.R2_en       = r2_en_q;
  assign bus.R2_Addr     = r2_addr_q;
  assign bus.enable      = alu_en_q;
  assign bus.op_code     = op_code_q;
  assign bus.W_en        = w_en_q;
  assign bus.W_Addr      = w_addr_q;
  assign bus.W_Data      = (state_q == StWb) ? res_q : '0;
  assign bus.Retire      = retire_q;
  assign bus.Illegal     = illegal_q;
  assign bus.Retire_cnt  = cnt_q;
`ifdef EXEC_DIV0_TRAP_EN
  assign bus.Trap        = trap_q;
`endif

endmodule
